store_merge_unit: RTL and testbench

MEM-stage store unit; the write-direction counterpart of the load extraction path. It accepts sw/sh/sb store requests from the pipeline and drives a word-only data memory port. Misaligned or illegal requests are detected and no memory access is made for them. Sub-word stores use a read-modify-write sequence: it reads the containing word, merges the new byte or halfword at the lane selected by the address low bits, and writes the word back. It stalls the pipeline through `st_ready` while a store is in flight.

---
 rtl/store_pkg.sv | 34 +++
 rtl/store_byte_merge.sv | 32 +++
 rtl/store_merge_unit.sv | 116 +++++++++++
 tb/tb_store_merge_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared encodings and helpers for the MEM-stage store unit.
package store_pkg;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_ILL = 2'b11
    } st_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

    // Misaligned sw/sh and the reserved opcode never reach memory.
    function automatic logic addr_error(input logic [1:0] op, input logic [1:0] lo);
        case (op)
            ST_SW:   return lo != 2'b00;
            ST_SH:   return lo[0];
            ST_SB:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_byte_merge.sv
// Places a store byte/halfword into the lane of an existing word.
module store_byte_merge
    import store_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (op)
            ST_SB: begin
                case (lane)
                    2'd0:    merged[7:0]   = new_data[7:0];
                    2'd1:    merged[15:8]  = new_data[7:0];
                    2'd2:    merged[23:16] = new_data[7:0];
                    default: merged[31:24] = new_data[7:0];
                endcase
            end
            ST_SH: begin
                if (lane[1]) merged[31:16] = new_data[15:0];
                else         merged[15:0]  = new_data[15:0];
            end
            ST_SW:   merged = new_data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store unit: sw writes directly, sh/sb do read-modify-write on a word port.
//   state | meaning
//   IDLE  | ready, waiting for a store request
//   RD    | reading the containing word for a sub-word store
//   WR    | writing the (merged) word back
//   RESP  | one-cycle st_done or st_err pulse
module store_merge_unit
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_done,
    output logic        st_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_e      state, state_next;
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] wbuf;
    logic [31:0] merged;
    logic        err_q;
    logic        req_err;

    assign req_err = addr_error(st_op, st_addr[1:0]);

    store_byte_merge u_merge (
        .op       (op_q),
        .lane     (addr_q[1:0]),
        .old_word (mem_rdata),
        .new_data (data_q),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        st_ready   = 1'b0;
        st_done    = 1'b0;
        st_err     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    if (req_err)             state_next = RESP;
                    else if (st_op == ST_SW) state_next = WR;
                    else                     state_next = RD;
                end
            end
            RD: begin
                mem_req = 1'b1;
                if (mem_ack) state_next = WR;
            end
            WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_next = RESP;
            end
            RESP: begin
                st_done    = ~err_q;
                st_err     = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch and write buffer; rdata is only looked at on the RD ack edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= 2'b00;
            addr_q <= 32'h0;
            data_q <= 32'h0;
            wbuf   <= 32'h0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (st_valid) begin
                        op_q   <= st_op;
                        addr_q <= st_addr;
                        data_q <= st_data;
                        err_q  <= req_err;
                        if (!req_err && st_op == ST_SW) wbuf <= st_data;
                    end
                end
                RD: begin
                    if (mem_ack) wbuf <= merged;
                end
                RESP:    err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign mem_addr  = word_addr(addr_q);
    assign mem_wdata = wbuf;

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench: vector table plus delayed-memory and mid-RD reset sequences.
module tb_store_merge_unit;
    import store_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [1:0]  st_op = 2'b00;
    logic [31:0] st_addr = 32'h0;
    logic [31:0] st_data = 32'h0;
    logic        st_done;
    logic        st_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    store_merge_unit dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_op     (st_op),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_done   (st_done),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        int          lat;
        int          t0;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] init;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        err;
        int          lat;
        int          reqs;
    } vec_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    logic [31:0] mem_model [logic [31:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cycles = 0;
    int rd_delay = 0;
    int wr_delay = 0;
    int wait_cnt = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model with programmable wait states; also checks every write.
    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        if (!mem_req) begin
            wait_cnt = 0;
        end else begin
            req_cycles++;
            check("busy_not_ready", 32'(st_ready), 32'h0);
            if (wait_cnt == 0) begin
                cap_addr  = mem_addr;
                cap_we    = mem_we;
                cap_wdata = mem_wdata;
            end else begin
                check("hold_addr", mem_addr, cap_addr);
                check("hold_we", 32'(mem_we), 32'(cap_we));
                check("hold_wdata", mem_wdata, cap_wdata);
            end
            if (wait_cnt == (mem_we ? wr_delay : rd_delay)) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    mem_model[mem_addr] = mem_wdata;
                    if (wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %h data %h", mem_addr, mem_wdata);
                    end else begin
                        wr_t w;
                        w = wr_q.pop_front();
                        check("write_addr", mem_addr, w.addr);
                        check("write_data", mem_wdata, w.data);
                    end
                end else begin
                    mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    // Response scoreboard.
    always @(negedge clk) begin
        if (st_done || st_err) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: done %b err %b", st_done, st_err);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                check("resp_err", 32'(st_err), 32'(r.err));
                check("resp_done", 32'(st_done), 32'(!r.err));
                check("resp_latency", 32'(cyc - r.t0), 32'(r.lat));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic push, input logic err, input int lat,
                         input logic [31:0] waddr, input logic [31:0] wdata, output int t_acc);
        @(negedge clk);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_data  = data;
        for (int i = 0; i < 60; i++) begin
            if (st_ready) break;
            @(negedge clk);
        end
        if (!st_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: addr %h never accepted", addr);
            t_acc = -1;
            return;
        end
        t_acc = cyc;
        if (push) begin
            resp_q.push_back('{err, lat, cyc});
            if (!err) wr_q.push_back('{waddr, wdata});
        end
        @(posedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (resp_q.size() == 0 && wr_q.size() == 0) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL completion_timeout: %0d responses %0d writes outstanding", resp_q.size(), wr_q.size());
        resp_q.delete();
        wr_q.delete();
    endtask

    vec_t vecs[13];

    initial begin
        int t1, t2, base;

        vecs[0]  = '{ST_SW,  32'h0000_1004, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 2, 1};
        vecs[1]  = '{ST_SB,  32'h0000_2003, 32'h0000_00AB, 32'h1122_3344, 32'h0000_2000, 32'hAB22_3344, 1'b0, 3, 2};
        vecs[2]  = '{ST_SH,  32'h0000_3002, 32'hFFFF_5566, 32'h1122_3344, 32'h0000_3000, 32'h5566_3344, 1'b0, 3, 2};
        vecs[3]  = '{ST_SH,  32'h0000_3000, 32'hFFFF_5566, 32'h1122_3344, 32'h0000_3000, 32'h1122_5566, 1'b0, 3, 2};
        vecs[4]  = '{ST_SB,  32'h0000_2000, 32'h1234_56CD, 32'h1122_3344, 32'h0000_2000, 32'h1122_33CD, 1'b0, 3, 2};
        vecs[5]  = '{ST_SB,  32'h0000_2001, 32'h0000_00EF, 32'h1122_3344, 32'h0000_2000, 32'h1122_EF44, 1'b0, 3, 2};
        vecs[6]  = '{ST_SB,  32'h0000_2002, 32'h0000_0077, 32'h1122_3344, 32'h0000_2000, 32'h1177_3344, 1'b0, 3, 2};
        vecs[7]  = '{ST_SH,  32'h0000_4001, 32'h0000_1111, 32'h0000_0000, 32'h0000_4000, 32'h0000_0000, 1'b1, 1, 0};
        vecs[8]  = '{ST_SW,  32'h0000_4002, 32'h2222_2222, 32'h0000_0000, 32'h0000_4000, 32'h0000_0000, 1'b1, 1, 0};
        vecs[9]  = '{ST_ILL, 32'h0000_4000, 32'h3333_3333, 32'h0000_0000, 32'h0000_4000, 32'h0000_0000, 1'b1, 1, 0};
        vecs[10] = '{ST_SW,  32'h0000_4003, 32'h4444_4444, 32'h0000_0000, 32'h0000_4000, 32'h0000_0000, 1'b1, 1, 0};
        vecs[11] = '{ST_SH,  32'h0000_4003, 32'h5555_5555, 32'h0000_0000, 32'h0000_4000, 32'h0000_0000, 1'b1, 1, 0};
        vecs[12] = '{ST_SW,  32'h0000_8000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'h0000_8000, 32'hCAFE_F00D, 1'b0, 2, 1};

        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({st_ready, st_done, st_err, mem_req, mem_we}), 32'b10000);
        check("reset_addr", mem_addr, 32'h0);
        check("reset_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(st_ready), 32'h1);

        foreach (vecs[i]) begin
            mem_model[vecs[i].waddr] = vecs[i].init;
            base = req_cycles;
            issue(vecs[i].op, vecs[i].addr, vecs[i].data, 1'b1, vecs[i].err, vecs[i].lat,
                  vecs[i].waddr, vecs[i].wdata, t1);
            @(negedge clk);
            st_valid = 1'b0;
            wait_idle();
            check("mem_req_cycles", 32'(req_cycles - base), 32'(vecs[i].reqs));
        end

        // Slow memory: sb with 3 read waits and 2 write waits, then a held sw request.
        rd_delay = 3;
        wr_delay = 2;
        mem_model[32'h0000_5000] = 32'hA1B2_C3D4;
        base = req_cycles;
        issue(ST_SB, 32'h0000_5001, 32'h0000_0099, 1'b1, 1'b0, 8, 32'h0000_5000, 32'hA1B2_99D4, t1);
        issue(ST_SW, 32'h0000_6000, 32'h1234_5678, 1'b1, 1'b0, 4, 32'h0000_6000, 32'h1234_5678, t2);
        @(negedge clk);
        st_valid = 1'b0;
        wait_idle();
        check("back_to_back_gap", 32'(t2 - t1), 32'd9);
        check("slow_req_cycles", 32'(req_cycles - base), 32'd10);
        check("slow_mem_word", mem_model[32'h0000_5000], 32'hA1B2_99D4);

        // Reset while an sb is waiting in RD: abort, no write, no response.
        rd_delay = 3;
        wr_delay = 0;
        mem_model[32'h0000_7000] = 32'h55AA_55AA;
        base = req_cycles;
        issue(ST_SB, 32'h0000_7002, 32'h0000_0011, 1'b0, 1'b0, 0, 32'h0, 32'h0, t1);
        @(negedge clk);
        st_valid = 1'b0;
        check("rst_in_rd_req", 32'(mem_req), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_abort_ctrl", 32'({st_ready, st_done, st_err, mem_req, mem_we}), 32'b10000);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_abort_reqs", 32'(req_cycles - base), 32'd1);
        check("rst_abort_mem", mem_model[32'h0000_7000], 32'h55AA_55AA);
        check("rst_ready_after", 32'(st_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
